// File: rtl/mem_stage_sb.sv
// mem_stage_sb: memory pipeline stage with a FIFO store buffer, exact-match load forwarding
// and a single-outstanding memory port shared by loads and store-buffer drains.
module mem_stage_sb #(
  parameter int DATA_W = 32,
  parameter int RADDR_W = 6,
  parameter int SB_DEPTH = 4,
  localparam int PW = $clog2(SB_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               in_valid,
  input  logic               in_load,
  input  logic               in_store,
  input  logic [1:0]         in_size,
  input  logic               in_sign,
  input  logic [DATA_W-1:0]  in_addr,
  input  logic [DATA_W-1:0]  in_wdata,
  input  logic [DATA_W-1:0]  in_result,
  input  logic               in_regwe,
  input  logic [RADDR_W-1:0] in_regwaddr,
  output logic               busy,
  output logic               out_valid,
  output logic               out_regwe,
  output logic [RADDR_W-1:0] out_regwaddr,
  output logic [DATA_W-1:0]  out_wbdata,
  output logic [CW-1:0]      sb_count,
  output logic               mem_req,
  output logic               mem_we,
  output logic [DATA_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic [1:0]         mem_size,
  input  logic               mem_ack,
  input  logic [DATA_W-1:0]  mem_rdata
);
  typedef enum logic [1:0] {IDLE, LOAD_WAIT, DRAIN_WAIT, FLUSH} state_t;
  typedef struct packed {
    logic valid, load, store;
    logic [1:0] size;
    logic sign;
    logic [DATA_W-1:0] addr, wdata, result;
    logic regwe;
    logic [RADDR_W-1:0] regwaddr;
  } stage_t;

  stage_t stg_q, stg_d;
  state_t state_q, state_d;
  logic [DATA_W-1:0] sb_addr_q [SB_DEPTH];
  logic [DATA_W-1:0] sb_data_q [SB_DEPTH];
  logic [1:0] sb_size_q [SB_DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic flush_q, flush_d, ld_done_q, ld_done_d, m_we_q, m_we_d;
  logic [DATA_W-1:0] ld_data_q, ld_data_d, m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
  logic [1:0] m_size_q, m_size_d;
  logic fwd_hit, conflict, done, mem_ld, ack_ld, cap, push, pop, issue_ld, issue_dr;
  logic [DATA_W-1:0] fwd_data, raw;

  function automatic logic [DATA_W-1:0] ext(input logic [DATA_W-1:0] d, input logic [1:0] sz, input logic sg);
    return sz == 2'b10 ? {{(DATA_W-8){sg & d[7]}}, d[7:0]} :
           sz == 2'b01 ? {{(DATA_W-16){sg & d[15]}}, d[15:0]} : d;
  endfunction

  // Walk oldest to youngest so the youngest same-word entry decides forward vs. flush
  always_comb begin
    fwd_hit = 1'b0;
    conflict = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (CW'(i) < cnt_q && sb_addr_q[head_q + PW'(i)][DATA_W-1:2] == stg_q.addr[DATA_W-1:2]) begin
        fwd_hit = sb_addr_q[head_q + PW'(i)] == stg_q.addr && sb_size_q[head_q + PW'(i)] == stg_q.size;
        conflict = !fwd_hit;
        fwd_data = sb_data_q[head_q + PW'(i)];
      end
    end
  end

  always_comb begin
    ack_ld = state_q == LOAD_WAIT && mem_ack;
    pop = state_q == DRAIN_WAIT && mem_ack;
    done = stg_q.store ? cnt_q != CW'(SB_DEPTH) : stg_q.load ? fwd_hit | ld_done_q | ack_ld : 1'b1;
    busy = stg_q.valid & ~done;
    out_valid = stg_q.valid & done & ~stall;
    cap = ~stall & ~busy;
    push = out_valid & stg_q.store;
    mem_ld = stg_q.valid & stg_q.load & ~fwd_hit & ~ld_done_q;
    raw = fwd_hit ? fwd_data : ld_done_q ? ld_data_q : mem_rdata;
    out_wbdata = stg_q.load ? ext(raw, stg_q.size, stg_q.sign) : stg_q.result;
    out_regwe = out_valid & stg_q.regwe & ~stg_q.store;
    out_regwaddr = stg_q.regwaddr;
    stg_d = cap ? {in_valid, in_load, in_store, in_size, in_sign, in_addr, in_wdata, in_result, in_regwe, in_regwaddr} : stg_q;
    ld_done_d = cap ? 1'b0 : ld_done_q | ack_ld;
    ld_data_d = ack_ld ? mem_rdata : ld_data_q;
    head_d = head_q + PW'(pop);
    tail_d = tail_q + PW'(push);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  // flush_q keeps a conflicting load waiting until the whole buffer has drained
  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    m_we_d = m_we_q;
    m_addr_d = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_size_d = m_size_q;
    issue_ld = 1'b0;
    issue_dr = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_ld && !stall) begin
          if (conflict || flush_q) begin
            state_d = FLUSH;
            flush_d = 1'b1;
          end else issue_ld = 1'b1;
        end else issue_dr = cnt_q != '0;
      end
      FLUSH: begin
        issue_dr = cnt_q != '0;
        issue_ld = cnt_q == '0;
      end
      default: state_d = mem_ack ? IDLE : state_q;
    endcase
    if (issue_ld) begin
      state_d = LOAD_WAIT;
      flush_d = 1'b0;
      m_we_d = 1'b0;
      m_addr_d = stg_q.addr;
      m_wdata_d = '0;
      m_size_d = stg_q.size;
    end
    if (issue_dr) begin
      state_d = DRAIN_WAIT;
      m_we_d = 1'b1;
      m_addr_d = sb_addr_q[head_q];
      m_wdata_d = sb_data_q[head_q];
      m_size_d = sb_size_q[head_q];
    end
  end

  assign mem_req = state_q == LOAD_WAIT || state_q == DRAIN_WAIT;
  assign mem_we = m_we_q;
  assign mem_addr = m_addr_q;
  assign mem_wdata = m_wdata_q;
  assign mem_size = m_size_q;
  assign sb_count = cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stg_q <= '0;
      state_q <= IDLE;
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= '0;
      flush_q <= 1'b0;
      ld_done_q <= 1'b0;
      ld_data_q <= '0;
      m_we_q <= 1'b0;
      m_addr_q <= '0;
      m_wdata_q <= '0;
      m_size_q <= '0;
    end else begin
      stg_q <= stg_d;
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q <= cnt_d;
      flush_q <= flush_d;
      ld_done_q <= ld_done_d;
      ld_data_q <= ld_data_d;
      m_we_q <= m_we_d;
      m_addr_q <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_size_q <= m_size_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      sb_addr_q[tail_q] <= stg_q.addr;
      sb_data_q[tail_q] <= stg_q.wdata;
      sb_size_q[tail_q] <= stg_q.size;
    end
  end
endmodule
